// File: rtl/clock_seq_gate_pkg.sv
// Shared types and sizing helpers for the clock power-up/power-down sequencer.
// The state encoding is the 2-bit code visible on the state_dbg port.
package clock_seq_gate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_ON   = 2'd2,
    ST_DOWN = 2'd3
  } seq_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold 0..v-1, never less than one bit.
  function automatic int width_for(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/clock_seq_gate_cell.sv
// One gated clock channel: enable captured on the falling edge, then ANDed with
// the clock so the gate only moves while clk_in is low and no runt pulse escapes.
module clock_seq_gate_cell (
  input  logic clk_in,
  input  logic en,
  output logic clk_out
);

  logic gate_q;

  always_ff @(negedge clk_in) begin
    gate_q <= en;
  end

  assign clk_out = clk_in & gate_q;

endmodule

// File: rtl/clock_seq_gate.sv
// Multi-channel clock sequencer: releases gated clocks ch0 first with programmable
// delays while seq_en is high and withdraws them highest-first when it drops.
//
// Handshake: none -- seq_en is a level request sampled every posedge; busy/done
// report progress and en_out is a thermometer code of released channels.
module clock_seq_gate
  import clock_seq_gate_pkg::*;
#(
  parameter int N_CH      = 3,
  parameter int FIRST_DLY = 50_000_000,
  parameter int STEP_DLY  = 1_000_000,
  parameter int DOWN_DLY  = 1_000_000
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic            seq_en,
  output logic [N_CH-1:0] clk_out,
  output logic [N_CH-1:0] en_out,
  output logic            busy,
  output logic            done,
  output seq_state_t      state_dbg
);

  localparam int CNT_W = width_for(max3(FIRST_DLY, STEP_DLY, DOWN_DLY));
  localparam int IDX_W = width_for(N_CH);

  localparam logic [CNT_W-1:0] FIRST_LAST = CNT_W'(FIRST_DLY - 1);
  localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP_DLY - 1);
  localparam logic [CNT_W-1:0] DOWN_LAST  = CNT_W'(DOWN_DLY - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_CH - 1);

  seq_state_t       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [N_CH-1:0]  en_d;
  logic             busy_d, done_d;
  logic [CNT_W-1:0] up_last;
  int               n_on;

  // State register
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      idx    <= '0;
      en_out <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      idx    <= idx_d;
      en_out <= en_d;
      busy   <= busy_d;
      done   <= done_d;
    end
  end

  // en_out is thermometer coded, so its population count is both the lowest
  // disabled channel and one past the highest enabled channel.
  always_comb begin
    n_on = 0;
    for (int i = 0; i < N_CH; i++) begin
      if (en_out[i]) n_on = n_on + 1;
    end
  end

  assign up_last = (idx == '0) ? FIRST_LAST : STEP_LAST;

  // Next-state logic
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    en_d    = en_out;
    unique case (state)
      ST_IDLE: begin
        if (seq_en) begin
          state_d = ST_UP;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      ST_UP: begin
        if (!seq_en) begin
          cnt_d = '0;
          if (n_on == 0) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            state_d = ST_DOWN;
            idx_d   = IDX_W'(n_on - 1);
          end
        end else if (cnt == up_last) begin
          en_d[idx] = 1'b1;
          cnt_d     = '0;
          if (idx == LAST_IDX) state_d = ST_ON;
          else                 idx_d   = idx + 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_ON: begin
        if (!seq_en) begin
          state_d = ST_DOWN;
          cnt_d   = '0;
          idx_d   = LAST_IDX;
        end
      end
      ST_DOWN: begin
        if (seq_en) begin
          cnt_d = '0;
          // Reversal before the first channel dropped: everything is still on.
          if (n_on == N_CH) begin
            state_d = ST_ON;
          end else begin
            state_d = ST_UP;
            idx_d   = IDX_W'(n_on);
          end
        end else if (cnt == DOWN_LAST) begin
          en_d[idx] = 1'b0;
          cnt_d     = '0;
          if (idx == '0) state_d = ST_IDLE;
          else           idx_d   = idx - 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic (registered alongside state)
  always_comb begin
    busy_d = (state_d == ST_UP) || (state_d == ST_DOWN);
    done_d = (state_d == ST_ON);
  end

  assign state_dbg = state;

  for (genvar g = 0; g < N_CH; g++) begin : g_gate
    clock_seq_gate_cell u_cell (
      .clk_in (clk_in),
      .en     (en_out[g]),
      .clk_out(clk_out[g])
    );
  end

endmodule

// File: tb/tb_clock_seq_gate.sv
// Bench for clock_seq_gate: directed power-up/down/reversal/reset sequence, then
// random seq_en and reset traffic checked against a level-and-timer model.
module tb_clock_seq_gate;
  import clock_seq_gate_pkg::*;

  localparam int N_CH      = 3;
  localparam int FIRST_DLY = 5;
  localparam int STEP_DLY  = 4;
  localparam int DOWN_DLY  = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            seq_en = 1'b1;
  logic [N_CH-1:0] clk_out;
  logic [N_CH-1:0] en_out;
  logic            busy;
  logic            done;
  seq_state_t      state_dbg;

  int vectors = 0;
  int miscompares = 0;

  logic [N_CH+1:0] exp_q[$];
  logic [N_CH-1:0] model_en = '0;
  logic [N_CH-1:0] exp_gate = '0;
  bit              chk_live = 1'b0;
  bit              sim_done = 1'b0;

  // Clock / reset
  always #10 clk = ~clk;

  clock_seq_gate #(
    .N_CH(N_CH), .FIRST_DLY(FIRST_DLY), .STEP_DLY(STEP_DLY), .DOWN_DLY(DOWN_DLY)
  ) dut (
    .clk_in(clk), .rst(rst), .seq_en(seq_en), .clk_out(clk_out),
    .en_out(en_out), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: number of released channels, travel direction, edges left
  // until the next channel changes. Pushes the expected registered outputs.
  int lvl = 0;
  int dir = 0;
  int tmr = 0;

  function automatic int dly(input int l, input int d);
    if (d < 0) return DOWN_DLY;
    return (l == 0) ? FIRST_DLY : STEP_DLY;
  endfunction

  always @(posedge clk) begin
    int tgt;
    int nd;
    if (!rst) begin
      lvl = 0;
      dir = 0;
      tmr = 0;
    end else begin
      tgt = seq_en ? N_CH : 0;
      nd  = (lvl < tgt) ? 1 : ((lvl > tgt) ? -1 : 0);
      if (nd == 0) begin
        dir = 0;
      end else if (nd != dir) begin
        dir = nd;
        tmr = dly(lvl, dir);
      end else begin
        tmr = tmr - 1;
        if (tmr == 0) begin
          lvl = lvl + dir;
          if (lvl == tgt) dir = 0;
          else            tmr = dly(lvl, dir);
        end
      end
    end
    model_en = N_CH'((1 << lvl) - 1);
    exp_q.push_back({(dir != 0), (lvl == N_CH && dir == 0), model_en});
  end

  // Gate model: the channel gate follows the enable at each falling edge.
  always @(negedge clk) exp_gate = model_en;

  // Monitor: registered outputs, one expected entry per rising edge.
  always @(posedge clk) begin
    logic [N_CH+1:0] e;
    #1;
    if (exp_q.size() == 0) begin
      check("exp_q_underflow", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("en_out", 32'(en_out), 32'(e[N_CH-1:0]));
      check("busy",   32'(busy),   32'(e[N_CH+1]));
      check("done",   32'(done),   32'(e[N_CH]));
    end
  end

  // Gated clock sampling in both clock phases.
  always @(posedge clk) begin
    #2;
    if (chk_live) check("clk_out_high_phase", 32'(clk_out), 32'(exp_gate));
  end

  always @(negedge clk) begin
    #2;
    if (chk_live) check("clk_out_low_phase", 32'(clk_out), 32'd0);
  end

  // Pulse width: every gated high pulse must be a full 10 ns high phase.
  for (genvar g = 0; g < N_CH; g++) begin : g_pw
    time rise_t;
    bit  seen = 1'b0;
    always @(posedge clk_out[g]) begin
      rise_t = $time;
      seen   = chk_live;
    end
    always @(negedge clk_out[g]) begin
      if (chk_live && seen) check($sformatf("pulse_width_ch%0d", g), 32'($time - rise_t), 32'd10);
      seen = 1'b0;
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_pt(input string name, input logic [N_CH-1:0] e_en,
                        input logic e_busy, input logic e_done);
    check({name, "_en"},   32'(en_out), 32'(e_en));
    check({name, "_busy"}, 32'(busy),   32'(e_busy));
    check({name, "_done"}, 32'(done),   32'(e_done));
  endtask

  // Driver
  initial begin
    rst    = 1'b0;
    seq_en = 1'b1;
    wait_neg(1);
    chk_live = 1'b1;
    wait_neg(1);
    chk_pt("reset", 3'b000, 1'b0, 1'b0);
    rst = 1'b1;                                   // seq_en=1 sampled at edge k
    wait_neg(6);  chk_pt("up_k5", 3'b001, 1'b1, 1'b0);
    wait_neg(4);  chk_pt("up_k9", 3'b011, 1'b1, 1'b0);
    seq_en = 1'b0;                                // reversal mid-UP at 011
    wait_neg(3);  chk_pt("rev_p2", 3'b001, 1'b1, 1'b0);
    wait_neg(2);  chk_pt("rev_p4", 3'b000, 1'b0, 1'b0);
    seq_en = 1'b1;
    wait_neg(6);  chk_pt("up2_k5", 3'b001, 1'b1, 1'b0);
    wait_neg(4);  chk_pt("up2_k9", 3'b011, 1'b1, 1'b0);
    wait_neg(4);  chk_pt("up2_k13", 3'b111, 1'b0, 1'b1);
    seq_en = 1'b0;                                // power-down from ON
    wait_neg(3);  chk_pt("dn_m2", 3'b011, 1'b1, 1'b0);
    wait_neg(2);  chk_pt("dn_m4", 3'b001, 1'b1, 1'b0);
    seq_en = 1'b1;                                // reversal mid-DOWN at 001
    wait_neg(5);  chk_pt("rev_q4", 3'b011, 1'b1, 1'b0);
    wait_neg(4);  chk_pt("rev_q8", 3'b111, 1'b0, 1'b1);
    seq_en = 1'b0;
    wait_neg(3);  chk_pt("dn2_m2", 3'b011, 1'b1, 1'b0);
    wait_neg(2);  chk_pt("dn2_m4", 3'b001, 1'b1, 1'b0);
    wait_neg(2);  chk_pt("dn2_m6", 3'b000, 1'b0, 1'b0);
    seq_en = 1'b1;
    wait_neg(6);  chk_pt("up3_k5", 3'b001, 1'b1, 1'b0);
    wait_neg(4);  chk_pt("up3_k9", 3'b011, 1'b1, 1'b0);
    rst = 1'b0;                                   // reset mid-UP at 011
    wait_neg(1);  chk_pt("rst_mid", 3'b000, 1'b0, 1'b0);
    check("rst_mid_clk_out", 32'(clk_out), 32'd0);
    rst = 1'b1;

    // Random traffic: seq_en held for random spans, occasional short resets.
    for (int i = 0; i < 40; i++) begin
      seq_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b0;
        wait_neg($urandom_range(1, 2));
        rst = 1'b1;
      end
      wait_neg($urandom_range(1, 20));
    end
    seq_en = 1'b0;
    wait_neg(12);
    sim_done = 1'b1;
    wait_neg(1);
    if (exp_q.size() > 1) check("exp_q_drain", 32'(exp_q.size()), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    if (!sim_done) begin
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "bench timeout");
    end
  end

endmodule
